// File: rtl/ddr3_audio_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_audio_pkg : shared command codes, framing constant and FSM encoding for
//                  the DDR3 PCM reader.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ddr3_audio_pkg;

  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WR = 3'b000;

  // 256-bit word split into 32-bit stereo frames
  localparam int SAMPLES_PER_WORD = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CAL = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ABORT    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/audio_word_fifo.sv
// ----------------------------------------------------------------------------
// audio_word_fifo : synchronous first-word-fall-through FIFO holding returned
//                   DDR3 words until the unpacker consumes them.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module audio_word_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/ddr3_audio_reader.sv
// ----------------------------------------------------------------------------
// ddr3_audio_reader : streams a PCM region out of DDR3 with credit-limited
//                     reads and unpacks each word into eight stereo frames.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ddr3_audio_reader
  import ddr3_audio_pkg::*;
#(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              init_calib_complete,
  input  logic              cmd_ready,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [31:0]       smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              smp_last,
  output logic              busy,
  output logic              done
);

  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int LANE_W = $clog2(SAMPLES_PER_WORD);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(SAMPLES_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    num_q, num_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    popped_q, popped_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   fifo_rdata;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_clr;
  logic                credit_ok;
  logic                cmd_accept;
  logic                rsp;
  logic                smp_fire;
  logic                last_word;

  // Words buffered plus words in flight may never exceed the FIFO depth
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);
  assign cmd_accept = cmd_en && cmd_ready;
  assign rsp        = rd_data_valid && (outstanding_q != '0);
  assign fifo_push  = rsp && (state_q != ST_ABORT) && !fifo_full;
  assign smp_fire   = smp_valid && smp_ready;
  assign fifo_pop   = smp_fire && (lane_q == LANE_LAST);
  assign fifo_clr   = (state_q == ST_ABORT) && (outstanding_q == '0);
  assign last_word  = (popped_q == num_q - LEN_W'(1));

  audio_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .push    (fifo_push),
    .wr_data (rd_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      outstanding_q <= '0;
      lane_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      popped_q      <= popped_d;
      outstanding_q <= outstanding_d;
      lane_q        <= lane_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    num_d         = num_q;
    issued_d      = issued_q;
    popped_d      = popped_q;
    lane_d        = lane_q;
    done_d        = 1'b0;
    outstanding_d = outstanding_q;

    case ({cmd_accept, rsp})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (cmd_accept) begin
      addr_d   = addr_q + ADDR_W'(ADDR_STEP);
      issued_d = issued_q + LEN_W'(1);
    end

    if (smp_fire) begin
      lane_d = lane_q + LANE_W'(1);
      if (lane_q == LANE_LAST) popped_d = popped_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = base_addr;
          num_d         = num_words;
          issued_d      = '0;
          popped_d      = '0;
          lane_d        = '0;
          outstanding_d = '0;
          if (num_words == '0) done_d  = 1'b1;
          else                 state_d = ST_WAIT_CAL;
        end
      end
      ST_WAIT_CAL: begin
        if (stop)                     state_d = ST_ABORT;
        else if (init_calib_complete) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (stop)                                   state_d = ST_ABORT;
        else if (cmd_accept && (issued_d == num_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (stop) begin
          state_d = ST_ABORT;
        end else if (smp_fire && smp_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        // Late read data is dropped; the FIFO is flushed once nothing is in flight
        if (outstanding_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd       = CMD_RD;
    cmd_en    = (state_q == ST_ISSUE) && credit_ok && (issued_q < num_q);
    addr      = addr_q;
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    smp_valid = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && !fifo_empty;
    smp_data  = smp_valid ? fifo_rdata[{lane_q, 5'd0} +: 32] : 32'd0;
    smp_last  = smp_valid && (lane_q == LANE_LAST) && last_word;
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_audio_reader.sv
// ----------------------------------------------------------------------------
// tb_ddr3_audio_reader : randomized bench with a DDR3 memory model and a
//                        reference address/sample stream per run.
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ddr3_audio_reader;

  localparam int ADDR_W     = 29;
  localparam int DATA_W     = 256;
  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W      = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  num_words = '0;
  logic              init_calib_complete = 1'b0;
  logic              cmd_ready = 1'b0;
  logic [2:0]        cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_data_valid = 1'b0;
  logic [31:0]       smp_data;
  logic              smp_valid;
  logic              smp_ready = 1'b0;
  logic              smp_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  ddr3_audio_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .ADDR_STEP  (8),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .stop                (stop),
    .base_addr           (base_addr),
    .num_words           (num_words),
    .init_calib_complete (init_calib_complete),
    .cmd_ready           (cmd_ready),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .smp_data            (smp_data),
    .smp_valid           (smp_valid),
    .smp_ready           (smp_ready),
    .smp_last            (smp_last),
    .busy                (busy),
    .done                (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected command addresses, samples {last, data}, memory contents
  logic [ADDR_W-1:0] exp_addr [$];
  logic [32:0]       exp_smp  [$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] mem_q [$];

  int acc_cnt = 0, resp_cnt = 0, smp_cnt = 0, done_cnt = 0, cyc = 0;
  int done_cyc = 0, last_resp_cyc = 0, first_smp_cyc = 0, last_smp_cyc = 0;
  int p_smp = 100, p_cmd = 100, p_resp = 100;
  int cmd_cap = 1 << 30, resp_cap = 1 << 30;
  bit abort_mode = 1'b0;

  // Downstream, command-port and read-return driver
  initial forever begin
    @(posedge clk); #1;
    smp_ready = (int'($urandom_range(99, 0)) < p_smp);
    cmd_ready = (acc_cnt < cmd_cap) && (int'($urandom_range(99, 0)) < p_cmd);
    if (mem_q.size() > 0 && resp_cnt < resp_cap && int'($urandom_range(99, 0)) < p_resp) begin
      rd_data       = mem[mem_q.pop_front()];
      rd_data_valid = 1'b1;
      resp_cnt++;
      last_resp_cyc = cyc;
    end else begin
      rd_data       = '0;
      rd_data_valid = 1'b0;
    end
  end

  // Monitor: compares every accepted command and every handshaken sample
  initial begin
    logic              prev_cmd_pend;
    logic              prev_smp_pend;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_smp;
    logic [32:0]       e;
    prev_cmd_pend = 1'b0;
    prev_smp_pend = 1'b0;
    prev_addr     = '0;
    prev_smp      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_cmd_pend = 1'b0;
        prev_smp_pend = 1'b0;
      end else begin
        if (rd_data_valid) check_eq("fifo_push_when_full", dut.u_fifo.full, 1'b0);
        if (prev_cmd_pend && !abort_mode) begin
          check_eq("cmd_en_hold", cmd_en, 1'b1);
          check_eq("addr_hold", addr, prev_addr);
        end
        if (prev_smp_pend && !abort_mode) begin
          check_eq("smp_valid_hold", smp_valid, 1'b1);
          check_eq("smp_data_hold", smp_data, prev_smp);
        end
        if (abort_mode && (cmd_en || smp_valid))
          check_eq("abort_quiet", {cmd_en, smp_valid}, 2'b00);
        if (cmd_en && cmd_ready) begin
          check_eq("cmd_expected", exp_addr.size() != 0, 1'b1);
          check_eq("cmd_code", cmd, 3'b001);
          if (exp_addr.size() != 0) check_eq("cmd_addr", addr, exp_addr.pop_front());
          check_eq("credit_limit", (acc_cnt + 1 - smp_cnt / 8) <= FIFO_DEPTH, 1'b1);
          acc_cnt++;
          mem_q.push_back(addr);
        end
        if (smp_valid && smp_ready) begin
          check_eq("smp_expected", exp_smp.size() != 0, 1'b1);
          if (exp_smp.size() != 0) begin
            e = exp_smp.pop_front();
            check_eq("smp_data", smp_data, e[31:0]);
            check_eq("smp_last", smp_last, e[32]);
          end
          if (smp_cnt == 0) first_smp_cyc = cyc;
          last_smp_cyc = cyc;
          smp_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_cmd_pend = cmd_en && !cmd_ready;
        prev_addr     = addr;
        prev_smp_pend = smp_valid && !smp_ready;
        prev_smp      = smp_data;
      end
    end
  end

  task automatic setup_run(input logic [ADDR_W-1:0] b, input int n, input bit pat);
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] a;
    exp_addr.delete();
    exp_smp.delete();
    mem.delete();
    acc_cnt  = 0;
    resp_cnt = 0;
    smp_cnt  = 0;
    for (int w = 0; w < n; w++) begin
      a = b + ADDR_W'(8 * w);
      for (int k = 0; k < 8; k++)
        word[32*k +: 32] = pat ? (32'hA000_0000 + 32'(k)) : $urandom();
      mem[a] = word;
      exp_addr.push_back(a);
      for (int k = 0; k < 8; k++)
        exp_smp.push_back({(w == n - 1) && (k == 7), word[32*k +: 32]});
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input int n);
    @(posedge clk); #1;
    base_addr = b;
    num_words = LEN_W'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    check_eq({tag, "_done_seen"}, done_cnt != d0, 1'b1);
  endtask

  task automatic finish_run(input string tag, input int n);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, done, 1'b0);
    check_eq({tag, "_busy_low"}, busy, 1'b0);
    check_eq({tag, "_addr_left"}, exp_addr.size(), 0);
    check_eq({tag, "_smp_left"}, exp_smp.size(), 0);
    check_eq({tag, "_smp_count"}, smp_cnt, 8 * n);
  endtask

  task automatic run_test(input string tag, input logic [ADDR_W-1:0] b, input int n, input bit pat);
    int d0;
    setup_run(b, n, pat);
    d0 = done_cnt;
    pulse_start(b, n);
    @(negedge clk);
    check_eq({tag, "_busy_high"}, busy, 1'b1);
    wait_done(tag, d0, 4000);
    finish_run(tag, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd"}, cmd, 3'b001);
    check_eq({tag, "_cmd_en"}, cmd_en, 1'b0);
    check_eq({tag, "_addr"}, addr, '0);
    check_eq({tag, "_smp_valid"}, smp_valid, 1'b0);
    check_eq({tag, "_smp_data"}, smp_data, '0);
    check_eq({tag, "_smp_last"}, smp_last, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    bit  seen;
    int  n;
    logic [ADDR_W-1:0] b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Calibration gate
    init_calib_complete = 1'b0;
    setup_run(29'h100, 2, 1'b0);
    d0 = done_cnt;
    pulse_start(29'h100, 2);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_en) seen = 1'b1;
    end
    check_eq("cal_no_cmd", seen, 1'b0);
    check_eq("cal_busy", busy, 1'b1);
    init_calib_complete = 1'b1;
    wait_done("cal", d0, 1000);
    finish_run("cal", 2);

    // Lane order and no bubbles across words
    run_test("lanes", 29'h800, 2, 1'b1);
    check_eq("no_bubble_span", last_smp_cyc - first_smp_cyc, 15);

    // Credit limit under full backpressure
    p_smp = 0;
    setup_run(29'h4000, 20, 1'b0);
    d0 = done_cnt;
    pulse_start(29'h4000, 20);
    repeat (100) @(negedge clk);
    check_eq("bp_accepted", acc_cnt, FIFO_DEPTH);
    check_eq("bp_cmd_en_low", cmd_en, 1'b0);
    p_smp = 100;
    wait_done("bp", d0, 2000);
    finish_run("bp", 20);

    // Random cmd_ready stalls, return latency and downstream readiness
    p_cmd = 50; p_smp = 70; p_resp = 60;
    for (int r = 0; r < 6; r++) begin
      b = ADDR_W'($urandom()) & ~ADDR_W'(7);
      n = int'($urandom_range(12, 1));
      run_test("rand", b, n, 1'b0);
    end
    p_cmd = 100; p_smp = 100; p_resp = 100;

    // Abort with a pending command and two reads outstanding
    p_smp = 0; cmd_cap = 3; resp_cap = 1;
    setup_run(29'h2000, 10, 1'b0);
    d0 = done_cnt;
    pulse_start(29'h2000, 10);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt == 3 && resp_cnt == 1) break;
    end
    repeat (4) @(negedge clk);
    check_eq("abort_setup_acc", acc_cnt, 3);
    check_eq("abort_pending_cmd", cmd_en, 1'b1);
    exp_addr.delete();
    exp_smp.delete();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    abort_mode = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("abort_waits_for_reads", done_cnt, d0);
    resp_cap = 3;
    wait_done("abort", d0, 200);
    check_eq("abort_done_after_last_read", done_cyc > last_resp_cyc + 1, 1'b1);
    @(negedge clk);
    abort_mode = 1'b0;
    check_eq("abort_no_samples", smp_cnt, 0);
    check_eq("abort_busy_low", busy, 1'b0);
    cmd_cap = 1 << 30; resp_cap = 1 << 30; p_smp = 100;
    run_test("post_abort", 29'h3000, 3, 1'b0);

    // Zero-length request
    setup_run(29'h10, 0, 1'b0);
    pulse_start(29'h10, 0);
    @(negedge clk);
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    check_eq("zero_cmd_en", cmd_en, 1'b0);
    @(negedge clk);
    check_eq("zero_done_pulse", done, 1'b0);
    check_eq("zero_no_cmd", acc_cnt, 0);

    // Address wrap
    run_test("wrap", 29'h1FFF_FFF8, 2, 1'b0);

    // Reset while draining
    p_smp = 0;
    setup_run(29'h40, 4, 1'b0);
    pulse_start(29'h40, 4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt == 4 && resp_cnt == 4) break;
    end
    check_eq("drain_setup", resp_cnt, 4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_q.delete();
    p_smp = 100;
    run_test("post_rst", 29'h5000, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
